// File: rtl/axi_read_pkg.sv
// Shared types and defaults for the burst-framing read initiator and target.
// Holds the channel FSM state encoding and the default length width.
package axi_read_pkg;

  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_e;

  typedef logic [LEN_W_DEFAULT:0] beat_t;

endpackage

// File: rtl/axi_beat_counter.sv
// Saturating beat counter with clear/increment and position flags relative to a
// burst length (beats-minus-one encoding); shared by both ends of the read channel.
module axi_beat_counter
  import axi_read_pkg::*;
#(
  parameter int W = LEN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] len_i,
  output logic [W:0]   count_o,
  output logic         at_last_o,
  output logic         past_last_o
);

  logic [W:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + (W+1)'(1);
    end
  end

  // The count before an increment is the index of the beat being accepted.
  assign count_o     = count_q;
  assign at_last_o   = (count_q == {1'b0, len_i});
  assign past_last_o = (count_q >  {1'b0, len_i});

endmodule

// File: rtl/axi_read_initiator.sv
// Issues one read burst per accepted command, drains its beats and reports framing errors.
// Define AXI_READ_INITIATOR_TIMEOUT_EN to build the stall watchdog behind err_timeout.
module axi_read_initiator
  import axi_read_pkg::*;
#(
  parameter int LEN_W          = LEN_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             stall,
  output logic             arvalid,
  output logic [LEN_W-1:0] arlen,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  output logic             done,
  output logic [LEN_W:0]   beats,
  output logic             err_early,
  output logic             err_late,
  output logic             err_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e           state_q;
  logic             cmd_ready_q;
  logic             arvalid_q;
  logic [LEN_W-1:0] len_q;
  logic             done_q;
  logic             err_early_q;
  logic             err_late_q;
  logic             accept;
  logic             beat_acc;
  logic             at_last;
  logic             past_last;
  logic             timeout_fire;

  assign accept   = cmd_valid && cmd_ready_q;
  // NOTE: rready is the only output with a combinational input path, so a
  // sink stall takes effect in the same cycle rather than one beat late.
  assign rready   = (state_q == DATA) && !stall;
  assign beat_acc = rvalid && rready;

  axi_beat_counter #(.W(LEN_W)) u_beat_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (accept),
    .inc_i       (beat_acc),
    .len_i       (len_q),
    .count_o     (beats),
    .at_last_o   (at_last),
    .past_last_o (past_last)
  );

`ifdef AXI_READ_INITIATOR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_timeout_q;
  logic            in_phase;
  logic            handshake;

  assign in_phase     = (state_q == ADDR) || (state_q == DATA);
  assign handshake    = (arvalid_q && arready) || beat_acc;
  assign timeout_fire = in_phase && !handshake && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout  = err_timeout_q;

  // Counts consecutive handshake-free cycles while a burst is outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (!in_phase || handshake) wd_q <= '0;
      else                        wd_q <= wd_q + WD_W'(1);
      if (accept)            err_timeout_q <= 1'b0;
      else if (timeout_fire) err_timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      len_q       <= '0;
      done_q      <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            len_q       <= cmd_len;
            arvalid_q   <= 1'b1;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            state_q     <= ADDR;
          end
        end
        ADDR: begin
          if (timeout_fire) begin
            arvalid_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RESP;
          end else if (arready) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (timeout_fire) begin
            done_q  <= 1'b1;
            state_q <= RESP;
          end else if (beat_acc) begin
            if (rlast) begin
              if (!at_last && !past_last) err_early_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= RESP;
            end else if (at_last) begin
              err_late_q <= 1'b1;
            end
          end
        end
        RESP: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign arvalid   = arvalid_q;
  assign arlen     = len_q;
  assign done      = done_q;
  assign err_early = err_early_q;
  assign err_late  = err_late_q;

endmodule
